// File: rtl/hm01b0_capture_ctrl.sv
// hm01b0_capture_ctrl: HM01B0 capture sequencer; strips the active padding and emits a WIDTH x HEIGHT ROI stream.
// Ports: clock/nreset (async, active-low); camera hsync, vsync, pixdata;
//   control arm, continuous, abort; stream out_ready, out_valid, out_data, out_x, out_y,
//   out_sof, out_eol, out_eof; status busy, frame_done, frame_count, err_geometry, err_overflow.
module hm01b0_capture_ctrl #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int H_PAD  = 2,
  parameter int V_PAD  = 2
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  pixdata,
  input  logic        arm,
  input  logic        continuous,
  input  logic        abort,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_geometry,
  output logic        err_overflow
);
  localparam logic [15:0] X0        = 16'(H_PAD);
  localparam logic [15:0] X_LAST    = 16'(H_PAD + WIDTH - 1);
  localparam logic [15:0] Y0        = 16'(V_PAD);
  localparam logic [15:0] Y_LAST    = 16'(V_PAD + HEIGHT - 1);
  localparam logic [15:0] LINE_LEN  = 16'(WIDTH + 2 * H_PAD);
  localparam logic [15:0] FRAME_LEN = 16'(HEIGHT + 2 * V_PAD);

  typedef enum logic [1:0] {IDLE, WAIT_VLOW, WAIT_VHIGH, ACTIVE} state_t;

  state_t      state, state_d;
  logic        s_hsync, s_vsync, p_hsync, p_vsync, cont;
  logic [7:0]  s_pix;
  logic [15:0] pc, lc, pc_eff, pc_inc, lc_inc, lc_eff;
  logic        h_rise, h_fall, v_rise, v_fall;
  logic        start, fr_start, act, fwd, fr_end, geo_bad;

  assign h_rise = s_hsync & ~p_hsync;
  assign h_fall = ~s_hsync & p_hsync;
  assign v_rise = s_vsync & ~p_vsync;
  assign v_fall = ~s_vsync & p_vsync;

  // pc counts hsync-high samples; the h_rise sample itself is index 0
  assign pc_eff = h_rise ? 16'd0 : pc;
  assign pc_inc = (pc_eff == 16'hFFFF) ? pc_eff : pc_eff + 16'd1;
  assign lc_inc = (lc == 16'hFFFF) ? lc : lc + 16'd1;
  // frame-size check must include a line that ends in the same cycle
  assign lc_eff = h_fall ? lc_inc : lc;

  assign act      = (state == ACTIVE) & ~abort;
  assign start    = (state == IDLE) & arm & ~abort;
  assign fr_start = (state == WAIT_VHIGH) & v_rise & ~abort;
  assign fr_end   = act & v_fall;
  assign fwd      = act & s_hsync & (pc_eff >= X0) & (pc_eff <= X_LAST) & (lc >= Y0) & (lc <= Y_LAST);
  assign geo_bad  = act & ((h_fall & (pc != LINE_LEN)) | (v_fall & ((lc_eff != FRAME_LEN) | s_hsync)));
  assign busy     = state != IDLE;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:       if (arm) state_d = s_vsync ? WAIT_VLOW : WAIT_VHIGH;
      WAIT_VLOW:  if (v_fall) state_d = WAIT_VHIGH;
      WAIT_VHIGH: if (v_rise) state_d = ACTIVE;
      ACTIVE:     if (v_fall) state_d = cont ? WAIT_VHIGH : IDLE;
      default:    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge nreset)
    if (!nreset) state <= IDLE;
    else state <= state_d;

  always_ff @(posedge clock or negedge nreset)
    if (!nreset) begin
      s_hsync      <= 1'b0;
      s_vsync      <= 1'b0;
      p_hsync      <= 1'b0;
      p_vsync      <= 1'b0;
      s_pix        <= '0;
      cont         <= 1'b0;
      pc           <= '0;
      lc           <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_x        <= '0;
      out_y        <= '0;
      out_sof      <= 1'b0;
      out_eol      <= 1'b0;
      out_eof      <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      err_geometry <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      s_hsync <= hsync;
      s_vsync <= vsync;
      s_pix   <= pixdata;
      p_hsync <= s_hsync;
      p_vsync <= s_vsync;
      if (start) cont <= continuous;
      if (fr_start) begin
        pc <= '0;
        lc <= '0;
      end else if (act) begin
        if (s_hsync) pc <= pc_inc;
        if (h_fall) lc <= lc_inc;
      end
      out_valid <= fwd;
      if (fwd) begin
        out_data <= s_pix;
        out_x    <= pc_eff - X0;
        out_y    <= lc - Y0;
      end
      out_sof      <= fwd & (pc_eff == X0) & (lc == Y0);
      out_eol      <= fwd & (pc_eff == X_LAST);
      out_eof      <= fwd & (pc_eff == X_LAST) & (lc == Y_LAST);
      frame_done   <= fr_end;
      frame_count  <= frame_count + {15'd0, fr_end};
      err_geometry <= start ? 1'b0 : err_geometry | geo_bad;
      err_overflow <= start ? 1'b0 : err_overflow | (out_valid & ~out_ready);
    end
endmodule

// File: tb/tb_hm01b0_capture_ctrl.sv
// tb_hm01b0_capture_ctrl: randomized camera model with a pixel-rule scoreboard for hm01b0_capture_ctrl.
module tb_hm01b0_capture_ctrl;
  localparam int W    = 16;
  localparam int H    = 8;
  localparam int HP   = 2;
  localparam int VP   = 2;
  localparam int LINE = W + 2 * HP;
  localparam int NL   = H + 2 * VP;

  logic clock = 1'b0, nreset, hsync, vsync, arm, continuous, abort, out_ready;
  logic [7:0] pixdata, out_data;
  logic [15:0] out_x, out_y, frame_count;
  logic out_valid, out_sof, out_eol, out_eof, busy, frame_done, err_geometry, err_overflow;
  logic [63:0] outs;

  int checks = 0, errors = 0, fd_cnt = 0, pix_cnt = 0, fc_exp = 0;
  logic [42:0] q[$];

  always #5 clock = ~clock;

  hm01b0_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .H_PAD(HP), .V_PAD(VP)) dut (
    .clock(clock), .nreset(nreset), .hsync(hsync), .vsync(vsync), .pixdata(pixdata),
    .arm(arm), .continuous(continuous), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count),
    .err_geometry(err_geometry), .err_overflow(err_overflow)
  );

  assign outs = {out_valid, out_data, out_x, out_y, out_sof, out_eol, out_eof, busy,
                 frame_done, frame_count, err_geometry, err_overflow};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_done) fd_cnt++;
    if (out_valid) begin
      pix_cnt++;
      if (q.size() == 0) check("unexpected_pixel", {out_x, out_y}, 64'hFFFF_FFFF);
      else check("pixel", {out_data, out_x, out_y, out_sof, out_eol, out_eof}, q.pop_front());
    end
  end

  // Camera frame. ROI rule: sample i of line l is output iff HP<=i<HP+W and VP<=l<VP+H,
  // as long as capture is expected. Negative line indices disable the optional events.
  task automatic frame(input int nl, input int bad_l, input int bad_len, input bit cap_in,
                       input int arm_l, input int abort_l, input int rst_l, input int drop_l);
    bit cap = cap_in;
    int x, y;
    @(negedge clock);
    vsync = 1'b1;
    repeat (3) @(negedge clock);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == bad_l) ? bad_len : LINE;
      for (int i = 0; i < len; i++) begin
        hsync = 1'b1;
        pixdata = 8'($urandom);
        arm = (l == arm_l) && (i == 0);
        if (l == abort_l && i == 4) cap = 1'b0;
        abort = (l == abort_l) && (i == 5);
        out_ready = !((l == drop_l) && i >= 5 && i < 10);
        if (l == rst_l && i == 7) begin
          cap = 1'b0;
          #2 nreset = 1'b0;
          #1 check("async_reset_outs", outs, 64'd0);
          q.delete();
        end else nreset = 1'b1;
        x = i - HP;
        y = l - VP;
        if (cap && x >= 0 && x < W && y >= 0 && y < H)
          q.push_back({pixdata, 16'(x), 16'(y), x == 0 && y == 0, x == W - 1, x == W - 1 && y == H - 1});
        @(negedge clock);
      end
      hsync = 1'b0;
      arm = 1'b0;
      abort = 1'b0;
      out_ready = 1'b1;
      nreset = 1'b1;
      repeat ($urandom_range(2, 5)) @(negedge clock);
    end
    vsync = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic pulse_arm(input bit c);
    @(negedge clock);
    continuous = c;
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  task automatic status(input string tag, input int fd, input bit geo, input bit ovf);
    check({tag, "_leftover"}, q.size(), 0);
    check({tag, "_frame_done"}, fd_cnt, fd);
    check({tag, "_frame_count"}, frame_count, fc_exp);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err_geometry"}, err_geometry, geo);
    check({tag, "_err_overflow"}, err_overflow, ovf);
    fd_cnt = 0;
    pix_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; hsync = 1'b0; vsync = 1'b0; pixdata = '0;
    arm = 1'b0; continuous = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outs", outs, 64'd0);
    nreset = 1'b1;
    repeat (3) @(negedge clock);

    pulse_arm(1'b0);
    check("armed_busy", busy, 1);
    frame(NL, -1, 0, 1'b1, -1, -1, -1, -1);
    fc_exp = 1;
    check("nominal_pixels", pix_cnt, W * H);
    status("nominal", 1, 0, 0);

    frame(NL, -1, 0, 1'b0, 5, -1, -1, -1);
    check("midarm_no_pixels", pix_cnt, 0);
    check("midarm_waiting", busy, 1);
    frame(NL, -1, 0, 1'b1, -1, -1, -1, -1);
    fc_exp = 2;
    check("midarm_pixels", pix_cnt, W * H);
    status("midarm", 1, 0, 0);

    pulse_arm(1'b1);
    continuous = 1'b0;
    repeat (3) frame(NL, -1, 0, 1'b1, -1, -1, -1, -1);
    check("cont_pixels", pix_cnt, 3 * W * H);
    check("cont_still_busy", busy, 1);
    frame(NL, -1, 0, 1'b1, -1, 4, -1, -1);
    fc_exp = 5;
    status("continuous", 3, 0, 0);

    pulse_arm(1'b0);
    frame(NL, 6, W, 1'b1, -1, -1, -1, -1);
    fc_exp = 6;
    repeat (10) @(negedge clock);
    status("geo_line", 1, 1, 0);
    pulse_arm(1'b0);
    check("geo_cleared_by_arm", err_geometry, 0);
    frame(8, -1, 0, 1'b1, -1, -1, -1, -1);
    fc_exp = 7;
    status("geo_frame", 1, 1, 0);
    pulse_arm(1'b0);
    frame(NL, -1, 0, 1'b1, -1, -1, -1, -1);
    fc_exp = 8;
    status("geo_clean", 1, 0, 0);

    pulse_arm(1'b0);
    frame(NL, -1, 0, 1'b1, -1, -1, -1, 5);
    fc_exp = 9;
    check("ovf_pixels", pix_cnt, W * H);
    status("overflow", 1, 0, 1);

    pulse_arm(1'b0);
    frame(NL, -1, 0, 1'b1, -1, -1, 4, -1);
    fc_exp = 0;
    status("reset_race", 0, 0, 0);

    @(negedge clock);
    arm = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    arm = 1'b0;
    abort = 1'b0;
    @(negedge clock);
    check("arm_abort_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
